// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Flag indices address the registered N/Z/C/V vector in the top level.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    localparam int unsigned FLAG_N    = 0;
    localparam int unsigned FLAG_Z    = 1;
    localparam int unsigned FLAG_C    = 2;
    localparam int unsigned FLAG_V    = 3;
    localparam int unsigned NUM_FLAGS = 4;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: diff = a - b - borrow_in, with borrow out.
// Written as explicit gates, the counterpart of the adder cell.
module full_subtractor (
    output logic diff,
    output logic borrow_out,
    input  logic a,
    input  logic b,
    input  logic borrow_in
);

    logic a_xor_b;
    logic not_a_and_b;
    logic same_and_bin;

    assign a_xor_b      = a ^ b;
    assign diff         = a_xor_b ^ borrow_in;
    assign not_a_and_b  = ~a & b;
    assign same_and_bin = ~a_xor_b & borrow_in;
    assign borrow_out   = not_a_and_b | same_and_bin;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one reused full-subtractor cell and a registered borrow.
// Define SERIAL_SUB_FLAGS_EN to generate the N/Z/C/V flag registers; otherwise flags read 0.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    sub_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, result_q;
    logic [CNT_W-1:0] cnt_q;
    logic             borrow_q;
    logic             cell_diff, cell_bout;
    logic             accept, last_bit;

    assign accept   = start && (state_q != RUN);
    assign last_bit = (state_q == RUN) && (cnt_q == LAST_BIT);

    // Operands rotate right, so bit 0 always holds the bit being processed.
    full_subtractor u_cell (
        .diff       (cell_diff),
        .borrow_out (cell_bout),
        .a          (a_q[0]),
        .b          (b_q[0]),
        .borrow_in  (borrow_q)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: state_d = start ? RUN : IDLE;
            RUN:        state_d = (cnt_q == LAST_BIT) ? DONE : RUN;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
        end else if (accept) begin
            a_q      <= a;
            b_q      <= b;
            result_q <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
        end else if (state_q == RUN) begin
            a_q             <= {a_q[0], a_q[WIDTH-1:1]};
            b_q             <= {b_q[0], b_q[WIDTH-1:1]};
            result_q[cnt_q] <= cell_diff;
            borrow_q        <= cell_bout;
            if (!last_bit) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign result = result_q;

`ifdef SERIAL_SUB_FLAGS_EN
    logic [NUM_FLAGS-1:0] flags_q;
    logic [WIDTH-1:0]     result_fin;

    // Final result as it will be after the last RUN edge (MSB not yet stored).
    always_comb begin
        result_fin            = result_q;
        result_fin[WIDTH-1]   = cell_diff;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= '0;
        end else if (accept) begin
            flags_q <= '0;
        end else if (last_bit) begin
            flags_q[FLAG_N] <= cell_diff;
            flags_q[FLAG_Z] <= ~|result_fin;
            flags_q[FLAG_C] <= ~cell_bout;
            // On the last bit a_q[0]/b_q[0] hold the operand sign bits.
            flags_q[FLAG_V] <= (a_q[0] ^ b_q[0]) & (cell_diff ^ a_q[0]);
        end
    end

    assign negative = flags_q[FLAG_N];
    assign zero     = flags_q[FLAG_Z];
    assign carry    = flags_q[FLAG_C];
    assign overflow = flags_q[FLAG_V];
`else
    assign negative = 1'b0;
    assign zero     = 1'b0;
    assign carry    = 1'b0;
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8: driver pushes model results,
// a monitor pops and compares on every done pulse.
module tb_serial_subtractor;

    localparam int W = 8;

    typedef struct packed {
        logic [7:0] res;
        logic [3:0] flg;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy, done, negative, zero, carry, overflow;
    logic [7:0] result;
    logic [3:0] flags_now;

    exp_t exp_q[$];
    exp_t last_e;
    int   checks = 0;
    int   passes = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .negative (negative),
        .zero     (zero),
        .carry    (carry),
        .overflow (overflow)
    );

    always #500 clk = ~clk;

    assign flags_now = {negative, zero, carry, overflow};

    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        int   sd;
        e.res = x - y;
        sd    = int'($signed(x)) - int'($signed(y));
`ifdef SERIAL_SUB_FLAGS_EN
        e.flg = {e.res[7], (e.res == 8'd0), (x >= y), ((sd > 127) || (sd < -128))};
`else
        e.flg = 4'b0000;
`endif
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // Monitor: compares every done pulse against the scoreboard.
    logic prev_done = 1'b0;
    int   busy_run = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            busy_run  = 0;
            prev_done = 1'b0;
        end else begin
            if (done) begin
                check("done_one_cycle", prev_done, 0);
                check("busy_cycles", busy_run, W);
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_done: got done with result %0h, required no done", result);
                end else begin
                    last_e = exp_q.pop_front();
                    check("result", result, last_e.res);
                    check("flags_nzcv", flags_now, last_e.flg);
                end
            end
            busy_run  = busy ? busy_run + 1 : 0;
            prev_done = done;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("idle_timeout", 1, 0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) check("done_timeout", exp_q.size(), 0);
    endtask

    // Issue one op at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [7:0] x, input logic [7:0] y);
        wait_idle();
        a     = x;
        b     = y;
        start = 1'b1;
        exp_q.push_back(model(x, y));
        @(negedge clk);
        start = 1'b0;
        check("busy_after_accept", busy, 1);
        check("result_cleared", result, 0);
        check("flags_cleared", flags_now, 0);
    endtask

    initial begin
        logic [7:0] da [7];
        logic [7:0] db [7];
        exp_t       e;
        int         n;
        da = '{8'h05, 8'h03, 8'h80, 8'h7F, 8'h07, 8'h00, 8'hFF};
        db = '{8'h03, 8'h05, 8'h01, 8'hFF, 8'h07, 8'hFF, 8'h00};

        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        check("reset_flags", flags_now, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed cases, each followed by a hold check in idle.
        for (int i = 0; i < 7; i++) begin
            issue(da[i], db[i]);
            wait_drain();
            repeat (2) @(negedge clk);
            e = model(da[i], db[i]);
            check("result_hold", result, e.res);
            check("flags_hold", flags_now, e.flg);
        end

        // Start held through DONE: second op starts with no idle cycle.
        wait_idle();
        a     = 8'h07;
        b     = 8'h07;
        start = 1'b1;
        exp_q.push_back(model(8'h07, 8'h07));
        @(negedge clk);
        a = 8'h5A;
        b = 8'hC3;
        exp_q.push_back(model(8'h5A, 8'hC3));
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("b2b_done_timeout", 1, 0);
        @(negedge clk);
        start = 1'b0;
        check("back_to_back_busy", busy, 1);
        wait_drain();

        // Start and operand changes during RUN are ignored.
        issue(8'h9C, 8'h21);
        repeat (3) begin
            @(negedge clk);
            start = 1'b1;
            a     = 8'($urandom);
            b     = 8'($urandom);
        end
        start = 1'b0;
        wait_drain();

        // Reset at RUN bit 4 discards the op.
        issue(8'h55, 8'h2A);
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        check("midreset_result", result, 0);
        check("midreset_flags", flags_now, 0);
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        issue(8'h55, 8'h2A);
        wait_drain();

        // Random ops, issued back-to-back as soon as busy drops.
        for (int i = 0; i < 40; i++) begin
            issue(8'($urandom), 8'($urandom));
        end
        wait_drain();
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
